// File: rtl/delta_reg_bank.sv
// Per-channel change monitor: registers each input value, qualifies changes by mode,
// and keeps sticky flags, saturating event counters and overflow flags until read.
module delta_reg_bank #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                           CLK,
   input  logic                           RSTN,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   VALUE_IN,
   input  logic [2*NUM_CH-1:0]            MODE,
   input  logic [NUM_CH-1:0]              READ_EVENT,
   input  logic [NUM_CH-1:0]              IRQ_MASK,
   output logic [NUM_CH*DATA_WIDTH-1:0]   VALUE_OUT,
   output logic [NUM_CH-1:0]              VALUE_CHANGE,
   output logic [NUM_CH*CNT_WIDTH-1:0]    CHANGE_CNT,
   output logic [NUM_CH-1:0]              OVERFLOW,
   output logic                           IRQ
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   endfunction

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DATA_WIDTH-1:0] cur;
      logic [DATA_WIDTH-1:0] sample_p1;
      logic [1:0]            mode;
      logic                  read;
      logic                  hit;
      logic                  flag_p1;
      logic [CNT_WIDTH-1:0]  cnt_p1;
      logic                  ovf_p1;

      assign cur  = VALUE_IN[i*DATA_WIDTH +: DATA_WIDTH];
      assign mode = MODE[2*i +: 2];
      assign read = READ_EVENT[i];

      // Qualification compares the live input against the previously captured sample.
      always_comb begin
         hit = 1'b0;
         unique case (mode)
            2'b00:   hit = (cur != sample_p1);
            2'b01:   hit = (cur >  sample_p1);
            2'b10:   hit = (cur <  sample_p1);
            default: hit = 1'b0;
         endcase
      end

      // Stage p1: sample capture and status update; a read never swallows a coincident event.
      always_ff @(posedge CLK) begin
         if (!RSTN) begin
            sample_p1 <= '0;
            flag_p1   <= 1'b0;
            cnt_p1    <= '0;
            ovf_p1    <= 1'b0;
         end else begin
            sample_p1 <= cur;
            flag_p1   <= hit | (flag_p1 & ~read);
            if (read) begin
               cnt_p1 <= hit ? CNT_ONE : '0;
               ovf_p1 <= 1'b0;
            end else if (hit) begin
               cnt_p1 <= sat_inc(cnt_p1);
               ovf_p1 <= ovf_p1 | (cnt_p1 == CNT_MAX);
            end
         end
      end

      assign VALUE_OUT[i*DATA_WIDTH +: DATA_WIDTH] = sample_p1;
      assign VALUE_CHANGE[i]                       = flag_p1;
      assign CHANGE_CNT[i*CNT_WIDTH +: CNT_WIDTH]  = cnt_p1;
      assign OVERFLOW[i]                           = ovf_p1;
   end

   assign IRQ = |(VALUE_CHANGE & ~IRQ_MASK);

endmodule

// File: doc/delta_reg_bank.md
DELTA_REG_BANK -- requirements
Module: delta_reg_bank

Interface
REQ-001 Parameter NUM_CH, default 4: channel count, legal 1..32.
REQ-002 Parameter DATA_WIDTH, default 32: bits per channel value.
REQ-003 Parameter CNT_WIDTH, default 8: bits per channel change counter, legal 2..16.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RSTN  input  1  synchronous, active-low reset.
REQ-006 VALUE_IN  input  NUM_CH*DATA_WIDTH  monitored values; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 MODE  input  2*NUM_CH  per-channel detect mode: 00 any change, 01 increase (unsigned), 10 decrease (unsigned), 11 disabled.
REQ-008 READ_EVENT  input  NUM_CH  per-channel read strobe; one-cycle pulse clears that channel's status.
REQ-009 IRQ_MASK  input  NUM_CH  per-channel interrupt mask; 1 = masked.
REQ-010 VALUE_OUT  output  NUM_CH*DATA_WIDTH  registered sample of VALUE_IN, same packing.
REQ-011 VALUE_CHANGE  output  NUM_CH  per-channel sticky change flag.
REQ-012 CHANGE_CNT  output  NUM_CH*CNT_WIDTH  per-channel saturating count of qualified events since last read.
REQ-013 OVERFLOW  output  NUM_CH  per-channel flag: event occurred while counter saturated.
REQ-014 IRQ  output  1  OR of unmasked change flags.

Function
REQ-015 VALUE_OUT[i] SHALL load VALUE_IN[i] every cycle RSTN=1, regardless of MODE.
REQ-016 Qualified event for channel i SHALL be computed combinationally from VALUE_IN[i] vs VALUE_OUT[i]: mode 00 any bit differs; 01 VALUE_IN > VALUE_OUT; 10 VALUE_IN < VALUE_OUT; 11 never.
REQ-017 MODE changes SHALL take effect on the same cycle's qualification; no state is retroactively altered.
REQ-018 On qualified event, VALUE_CHANGE[i] SHALL be 1 after the same edge at which VALUE_OUT[i] captures the new value (latency 1 cycle from VALUE_IN change).
REQ-019 VALUE_CHANGE[i] SHALL remain 1 until an edge with READ_EVENT[i]=1 and no qualified event, then go to 0.
REQ-020 Read and qualified event on the same edge: VALUE_CHANGE[i] SHALL be 1 (new event not lost).
REQ-021 CHANGE_CNT[i] SHALL increment by 1 per qualified event, saturating at 2^CNT_WIDTH-1.
REQ-022 READ_EVENT[i] without event SHALL clear CHANGE_CNT[i] to 0; with simultaneous event SHALL load 1.
REQ-023 OVERFLOW[i] SHALL set on a qualified event while CHANGE_CNT[i] = max, hold until read; read clears it even if simultaneous with an event.
REQ-024 READ_EVENT[i]=1 with VALUE_CHANGE[i]=0 SHALL be harmless (counter 0 stays 0).
REQ-025 Channels SHALL be fully independent; READ_EVENT bits may assert in any combination concurrently.
REQ-026 IRQ SHALL equal |(VALUE_CHANGE & ~IRQ_MASK), combinational from registers, no glitch-inducing input paths.
REQ-027 Mode 11 channel SHALL still track VALUE_OUT and still honour READ_EVENT clears.

Reset
REQ-028 While RSTN=0 at an edge: VALUE_OUT, VALUE_CHANGE, CHANGE_CNT, OVERFLOW SHALL go to 0; IRQ therefore 0; no events qualified.
REQ-029 First cycle after reset SHALL compare VALUE_IN against reset value 0; nonzero input qualifies per MODE.
REQ-030 Reset asserted mid-count or with pending flags SHALL discard all status without generating IRQ.

Verification
REQ-031 NUM_CH=4, DATA_WIDTH=8, MODE=00: ch0 input 0x00->0x5A -> next cycle VALUE_OUT[0]=0x5A, VALUE_CHANGE=0001, CHANGE_CNT[0]=1, IRQ=1; READ_EVENT=0001 -> flag 0, count 0, IRQ=0.
REQ-032 ch1 MODE=01: input 0x10->0x08 -> no flag; 0x08->0x20 -> VALUE_CHANGE[1]=1; ch2 MODE=10 mirror check; ch3 MODE=11 toggling every cycle -> flag/count stay 0, VALUE_OUT tracks.
REQ-033 CNT_WIDTH=2: ch0 toggles 4 times without read -> CHANGE_CNT[0]=3, OVERFLOW[0]=1; read -> both 0.
REQ-034 Read on same edge as new change -> VALUE_CHANGE stays 1, CHANGE_CNT=1, OVERFLOW=0.
REQ-035 IRQ_MASK=0001 with only ch0 flagged -> IRQ=0; unmask -> IRQ=1 same cycle.
REQ-036 Flags pending, RSTN=0 one cycle with VALUE_IN=0x33 -> all outputs 0; RSTN=1 -> next edge VALUE_CHANGE[0]=1 (0x33 vs 0).
